// File: rtl/mfm_sector_parser.sv
// mfm_sector_parser
// Turns the decoded MFM byte stream into floppy ID fields and data-field
// payload. After each sync mark it classifies the address mark. It captures
// the C/H/R/N ID bytes, streams data bytes with their offset, and checks the
// CRC-16-CCITT of each field. A residue of zero means the field is good.
module mfm_sector_parser #(
  parameter int MAX_SIZE_CODE = 3
) (
  input  logic        i_Clk,
  input  logic        i_Reset_n,
  input  logic [7:0]  i_Data,
  input  logic        i_Valid,
  input  logic        i_Sync,
  output logic [7:0]  o_Id_Cyl,
  output logic [7:0]  o_Id_Head,
  output logic [7:0]  o_Id_Sector,
  output logic [7:0]  o_Id_Size,
  output logic        o_Id_Valid,
  output logic        o_Id_Crc_Err,
  output logic [7:0]  o_Byte,
  output logic        o_Byte_Valid,
  output logic [10:0] o_Byte_Index,
  output logic        o_Sector_Done,
  output logic        o_Crc_Err,
  output logic        o_Abort
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ARMED      = 2'd1,
    ID_FIELD   = 2'd2,
    DATA_FIELD = 2'd3
  } state_t;

  // CRC seed after reset, and the CRC of the three A1 sync bytes. The sync
  // pulse stands for the whole A1 A1 A1 preamble. Extra A1 bytes seen while
  // armed are therefore only counted and are not folded in again.
  localparam logic [15:0] CRC_RESET = 16'hFFFF;
  localparam logic [15:0] CRC_SYNC  = 16'hCDB4;
  localparam logic [7:0]  MAX_N     = 8'(MAX_SIZE_CODE);

  // CRC-16-CCITT (poly 0x1021). MSB first, one whole byte per call.
  function automatic logic [15:0] crc_byte(input logic [15:0] crc,
                                           input logic [7:0]  d);
    logic [15:0] c;
    c = crc ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  state_t      state;
  logic [15:0] crc;
  logic [15:0] crc_nxt;
  logic [1:0]  a1_cnt;
  logic [10:0] fcnt;
  logic [7:0]  cyl_s;
  logic [7:0]  head_s;
  logic [7:0]  sec_s;
  logic [7:0]  size_s;
  logic        id_ok;
  logic [2:0]  ok_size;
  logic [11:0] len;

  assign crc_nxt = crc_byte(crc, i_Data);
  // The payload length comes from the size code of the last good ID field.
  assign len     = 12'd128 << ok_size;

  // Parser FSM: control state, field counters, CRC and all registered outputs.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state         <= IDLE;
      crc           <= CRC_RESET;
      a1_cnt        <= 2'd0;
      fcnt          <= 11'd0;
      cyl_s         <= 8'h00;
      head_s        <= 8'h00;
      sec_s         <= 8'h00;
      size_s        <= 8'h00;
      id_ok         <= 1'b0;
      ok_size       <= 3'd0;
      o_Id_Cyl      <= 8'h00;
      o_Id_Head     <= 8'h00;
      o_Id_Sector   <= 8'h00;
      o_Id_Size     <= 8'h00;
      o_Id_Valid    <= 1'b0;
      o_Id_Crc_Err  <= 1'b0;
      o_Byte        <= 8'h00;
      o_Byte_Valid  <= 1'b0;
      o_Byte_Index  <= 11'd0;
      o_Sector_Done <= 1'b0;
      o_Crc_Err     <= 1'b0;
      o_Abort       <= 1'b0;
    end else begin
      o_Id_Valid    <= 1'b0;
      o_Byte_Valid  <= 1'b0;
      o_Sector_Done <= 1'b0;
      o_Abort       <= 1'b0;

      if (i_Sync) begin
        // A sync mark always re-arms. Any byte in the same cycle is dropped.
        // If a field was in flight, it is abandoned.
        if (state == ID_FIELD || state == DATA_FIELD) o_Abort <= 1'b1;
        if (state == DATA_FIELD) id_ok <= 1'b0;
        state  <= ARMED;
        crc    <= CRC_SYNC;
        a1_cnt <= 2'd0;
        fcnt   <= 11'd0;
      end else if (i_Valid) begin
        case (state)
          IDLE: begin
            // Bytes are meaningless until a sync mark arrives.
          end

          ARMED: begin
            if (i_Data == 8'hA1) begin
              if (a1_cnt == 2'd3) begin
                o_Abort <= 1'b1;
                state   <= IDLE;
              end else begin
                a1_cnt <= a1_cnt + 2'd1;
              end
            end else if (i_Data == 8'hFE) begin
              crc   <= crc_nxt;
              fcnt  <= 11'd0;
              state <= ID_FIELD;
            end else if (i_Data == 8'hFB || i_Data == 8'hF8) begin
              // A data mark is accepted only after a good, supported ID.
              if (id_ok) begin
                crc   <= crc_nxt;
                fcnt  <= 11'd0;
                state <= DATA_FIELD;
              end else begin
                o_Abort <= 1'b1;
                state   <= IDLE;
              end
            end else begin
              o_Abort <= 1'b1;
              state   <= IDLE;
            end
          end

          ID_FIELD: begin
            crc  <= crc_nxt;
            fcnt <= fcnt + 11'd1;
            case (fcnt)
              11'd0:   cyl_s  <= i_Data;
              11'd1:   head_s <= i_Data;
              11'd2:   sec_s  <= i_Data;
              11'd3:   size_s <= i_Data;
              default: begin end
            endcase
            // The sixth byte is CRC-lo. The fold that includes it yields the
            // residue.
            if (fcnt == 11'd5) begin
              o_Id_Cyl     <= cyl_s;
              o_Id_Head    <= head_s;
              o_Id_Sector  <= sec_s;
              o_Id_Size    <= size_s;
              o_Id_Valid   <= 1'b1;
              o_Id_Crc_Err <= (crc_nxt != 16'h0000);
              id_ok        <= (crc_nxt == 16'h0000) && (size_s <= MAX_N);
              ok_size      <= size_s[2:0];
              state        <= IDLE;
            end
          end

          DATA_FIELD: begin
            crc  <= crc_nxt;
            fcnt <= fcnt + 11'd1;
            if ({1'b0, fcnt} < len) begin
              o_Byte       <= i_Data;
              o_Byte_Index <= fcnt;
              o_Byte_Valid <= 1'b1;
            end else if ({1'b0, fcnt} == len + 12'd1) begin
              o_Sector_Done <= 1'b1;
              o_Crc_Err     <= (crc_nxt != 16'h0000);
              id_ok         <= 1'b0;
              state         <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mfm_sector_parser.sv
// Testbench for mfm_sector_parser. Directed stimulus pushes the expected
// events into a queue. A monitor pops an entry and compares it each time the
// DUT raises an event output.
module tb_mfm_sector_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_Data = 8'h00;
  logic        i_Valid = 1'b0;
  logic        i_Sync = 1'b0;
  logic [7:0]  o_Id_Cyl, o_Id_Head, o_Id_Sector, o_Id_Size;
  logic        o_Id_Valid, o_Id_Crc_Err;
  logic [7:0]  o_Byte;
  logic        o_Byte_Valid;
  logic [10:0] o_Byte_Index;
  logic        o_Sector_Done, o_Crc_Err, o_Abort;

  mfm_sector_parser #(.MAX_SIZE_CODE(3)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Data(i_Data), .i_Valid(i_Valid),
    .i_Sync(i_Sync), .o_Id_Cyl(o_Id_Cyl), .o_Id_Head(o_Id_Head),
    .o_Id_Sector(o_Id_Sector), .o_Id_Size(o_Id_Size), .o_Id_Valid(o_Id_Valid),
    .o_Id_Crc_Err(o_Id_Crc_Err), .o_Byte(o_Byte), .o_Byte_Valid(o_Byte_Valid),
    .o_Byte_Index(o_Byte_Index), .o_Sector_Done(o_Sector_Done),
    .o_Crc_Err(o_Crc_Err), .o_Abort(o_Abort)
  );

  always #5 clk = ~clk;

  // Event kinds are one-hot, so several outputs firing at once show up as a
  // mismatch.
  localparam logic [3:0] K_ID = 4'd1, K_BYTE = 4'd2, K_DONE = 4'd4, K_ABORT = 4'd8;

  typedef struct packed {
    logic [3:0]  kind;
    logic [7:0]  a, b, c, d;
    logic        e;
    logic [10:0] idx;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  // Bit-serial CRC-16-CCITT reference.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic logic [15:0] crc_sync();
    logic [15:0] r;
    r = 16'hFFFF;
    for (int i = 0; i < 3; i++) r = crc_upd(r, 8'hA1);
    return r;
  endfunction

  task automatic push(input logic [3:0] k, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d, input logic e,
                      input logic [10:0] idx);
    ev_t ev;
    ev.kind = k; ev.a = a; ev.b = b; ev.c = c; ev.d = d; ev.e = e; ev.idx = idx;
    exp_q.push_back(ev);
  endtask

  // Monitor: compare every DUT event against the head of the queue.
  always @(negedge clk) begin
    ev_t act, ex;
    logic bad;
    if (rst_n && (o_Id_Valid || o_Byte_Valid || o_Sector_Done || o_Abort)) begin
      act.kind = {o_Abort, o_Sector_Done, o_Byte_Valid, o_Id_Valid};
      act.a = o_Id_Valid ? o_Id_Cyl : o_Byte;
      act.b = o_Id_Head; act.c = o_Id_Sector; act.d = o_Id_Size;
      act.e = o_Id_Valid ? o_Id_Crc_Err : o_Crc_Err;
      act.idx = o_Byte_Index;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got kind=%0d a=%h idx=%0d, required no event",
                 act.kind, act.a, act.idx);
      end else begin
        ex = exp_q.pop_front();
        bad = (act.kind != ex.kind);
        if (!bad) begin
          case (ex.kind)
            K_ID:   bad = (act.a != ex.a) || (act.b != ex.b) || (act.c != ex.c) ||
                          (act.d != ex.d) || (act.e != ex.e);
            K_BYTE: bad = (act.a != ex.a) || (act.idx != ex.idx);
            K_DONE: bad = (act.e != ex.e);
            default: bad = 1'b0;
          endcase
        end
        if (bad) begin
          fails++;
          $display("FAIL event_check: got kind=%0d a=%h b=%h c=%h d=%h e=%0d idx=%0d, required kind=%0d a=%h b=%h c=%h d=%h e=%0d idx=%0d",
                   act.kind, act.a, act.b, act.c, act.d, act.e, act.idx,
                   ex.kind, ex.a, ex.b, ex.c, ex.d, ex.e, ex.idx);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cyl"}, int'(o_Id_Cyl), 0);
    chk({tag, "_head"}, int'(o_Id_Head), 0);
    chk({tag, "_sector"}, int'(o_Id_Sector), 0);
    chk({tag, "_size"}, int'(o_Id_Size), 0);
    chk({tag, "_id_valid"}, int'(o_Id_Valid), 0);
    chk({tag, "_id_crc_err"}, int'(o_Id_Crc_Err), 0);
    chk({tag, "_byte"}, int'(o_Byte), 0);
    chk({tag, "_byte_valid"}, int'(o_Byte_Valid), 0);
    chk({tag, "_byte_index"}, int'(o_Byte_Index), 0);
    chk({tag, "_done"}, int'(o_Sector_Done), 0);
    chk({tag, "_crc_err"}, int'(o_Crc_Err), 0);
    chk({tag, "_abort"}, int'(o_Abort), 0);
  endtask

  // One clock of stimulus. The inputs are sampled on the next rising edge.
  task automatic cyc(input logic v, input logic s, input logic [7:0] d);
    i_Valid = v; i_Sync = s; i_Data = d;
    @(posedge clk); #1;
    i_Valid = 1'b0; i_Sync = 1'b0; i_Data = 8'h00;
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, 1'b0, d);
  endtask

  task automatic id_field(input logic do_sync, input logic [7:0] c, input logic [7:0] h,
                          input logic [7:0] r, input logic [7:0] n, input logic bad);
    logic [15:0] crc;
    logic [7:0]  lo;
    if (do_sync) cyc(1'b0, 1'b1, 8'h00);
    send(8'hA1); send(8'hA1);
    crc = crc_upd(crc_sync(), 8'hFE);
    crc = crc_upd(crc, c); crc = crc_upd(crc, h);
    crc = crc_upd(crc, r); crc = crc_upd(crc, n);
    send(8'hFE); send(c); send(h); send(r); send(n);
    send(crc[15:8]);
    lo = crc[7:0] ^ {7'd0, bad};
    push(K_ID, c, h, r, n, bad, 11'd0);
    send(lo);
  endtask

  task automatic data_field(input int n, input int flip_idx);
    logic [15:0] crc;
    logic [7:0]  b;
    int          len;
    len = 128 << n;
    cyc(1'b0, 1'b1, 8'h00);
    send(8'hA1); send(8'hA1);
    crc = crc_upd(crc_sync(), 8'hFB);
    send(8'hFB);
    for (int i = 0; i < len; i++) begin
      b   = 8'(i);
      crc = crc_upd(crc, b);
      if (i == flip_idx) b = b ^ 8'h01;
      push(K_BYTE, b, 8'h00, 8'h00, 8'h00, 1'b0, 11'(i));
      send(b);
    end
    send(crc[15:8]);
    push(K_DONE, 8'h00, 8'h00, 8'h00, 8'h00, (flip_idx >= 0), 11'd0);
    send(crc[7:0]);
  endtask

  task automatic abort_data_mark();
    cyc(1'b0, 1'b1, 8'h00);
    send(8'hA1); send(8'hA1);
    push(K_ABORT, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 11'd0);
    send(8'hFB);
  endtask

  initial begin
    // Reset state, both during reset and right after its release.
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_low");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("reset_idle");

    // Good ID, then a good 512-byte data field.
    id_field(1'b1, 8'h05, 8'h01, 8'h03, 8'h02, 1'b0);
    data_field(2, -1);

    // Good ID, then a data field with one payload bit flipped.
    id_field(1'b1, 8'h05, 8'h01, 8'h03, 8'h02, 1'b0);
    data_field(2, 7);

    // Bad ID CRC: report the error, then reject the following data mark.
    id_field(1'b1, 8'h06, 8'h00, 8'h01, 8'h02, 1'b1);
    abort_data_mark();

    // A non-mark byte after sync.
    cyc(1'b0, 1'b1, 8'h00);
    push(K_ABORT, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 11'd0);
    send(8'h55);

    // Four A1 bytes after sync: abort on the fourth.
    cyc(1'b0, 1'b1, 8'h00);
    send(8'hA1); send(8'hA1); send(8'hA1);
    push(K_ABORT, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 11'd0);
    send(8'hA1);

    // Size code 4 exceeds the maximum: the ID is reported, but data is rejected.
    id_field(1'b1, 8'h07, 8'h01, 8'h09, 8'h04, 1'b0);
    abort_data_mark();

    // Re-sync in the data field at payload byte 100, coincident with a byte.
    id_field(1'b1, 8'h10, 8'h00, 8'h20, 8'h02, 1'b0);
    cyc(1'b0, 1'b1, 8'h00);
    send(8'hA1); send(8'hA1); send(8'hFB);
    for (int i = 0; i < 100; i++) begin
      push(K_BYTE, 8'(i), 8'h00, 8'h00, 8'h00, 1'b0, 11'(i));
      send(8'(i));
    end
    push(K_ABORT, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 11'd0);
    cyc(1'b1, 1'b1, 8'd100);
    id_field(1'b0, 8'h0A, 8'h00, 8'h07, 8'h01, 1'b0);

    // Sync with a coincident byte: 0x55 is dropped, so no abort occurs.
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 8'h55);
    id_field(1'b0, 8'h22, 8'h01, 8'h05, 8'h03, 1'b0);

    // Reset asserted in the middle of a data field.
    id_field(1'b1, 8'h30, 8'h01, 8'h02, 8'h01, 1'b0);
    cyc(1'b0, 1'b1, 8'h00);
    send(8'hA1); send(8'hA1); send(8'hFB);
    for (int i = 0; i < 50; i++) begin
      push(K_BYTE, 8'(i + 1), 8'h00, 8'h00, 8'h00, 1'b0, 11'(i));
      send(8'(i + 1));
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Reset also clears the ID-ok flag, so a data mark is rejected.
    abort_data_mark();
    id_field(1'b1, 8'h44, 8'h00, 8'h11, 8'h02, 1'b0);

    repeat (5) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_events: got %0d events still pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
